// File: rtl/signed_divider.sv
// Iterative signed divider (MIPS DIV semantics) producing quotient on lo and remainder on hi.
// Restoring algorithm on magnitudes, one quotient bit per cycle, sign fix-up in a final cycle.
module signed_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             ready,
  output logic             div_zero,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] quo, rem, dsr;
  logic [CW-1:0]    cnt;
  logic             sign_q, sign_r;
  logic             accept_c, zero_c;
  logic [WIDTH:0]   shifted_c, diff_c;

  // Partial remainder shifted left with the next dividend bit, then trial subtract.
  assign shifted_c = {rem, quo[WIDTH-1]};
  assign diff_c    = shifted_c - {1'b0, dsr};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    zero_c    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (b != '0) begin
            accept_c  = 1'b1;
            state_nxt = PREP;
          end else begin
            zero_c = 1'b1;
          end
        end
      end
      PREP: state_nxt = ITER;
      ITER: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs; quo doubles as the shifting dividend.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      ready    <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      dsr      <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
    end else begin
      ready    <= 1'b0;
      div_zero <= zero_c;
      case (state)
        IDLE: begin
          if (accept_c) begin
            quo    <= a;
            dsr    <= b;
            sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
            sign_r <= a[WIDTH-1];
            busy   <= 1'b1;
          end
        end
        PREP: begin
          if (quo[WIDTH-1]) quo <= -quo;
          if (dsr[WIDTH-1]) dsr <= -dsr;
          rem <= '0;
          cnt <= CW'(WIDTH - 1);
        end
        ITER: begin
          if (!diff_c[WIDTH]) begin
            rem <= diff_c[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted_c[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          lo    <= sign_q ? -quo : quo;
          hi    <= sign_r ? -rem : rem;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_divider.sv
// Directed-vector bench for signed_divider: latency, sign cases, divide by zero, overlap, reset abort.
module tb_signed_divider;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] a, b, hi, lo;
  logic        ready, div_zero, busy;

  int checks   = 0;
  int failures = 0;

  signed_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .hi(hi), .lo(lo), .ready(ready), .div_zero(div_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request at edge E0 and watch 40 cycles; k counts edges after E0.
  // pulse_k: edge at which a second 9/3 start is sampled; reset_k: edge at which reset is sampled.
  task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv,
                     input int pulse_k, input int reset_k,
                     output int rdy_at, output int rdy_cnt, output int busy_cnt,
                     output logic [31:0] lo_s, output logic [31:0] hi_s);
    rdy_at = -1; rdy_cnt = 0; busy_cnt = 0; lo_s = '0; hi_s = '0;
    @(posedge clk); #1;
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h0000_0001;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (busy) busy_cnt++;
      if (ready) begin
        rdy_cnt++;
        if (rdy_at < 0) rdy_at = k;
      end
      if (k == 34) begin
        lo_s = lo;
        hi_s = hi;
      end
      if (reset_k >= 0 && k == reset_k) begin
        check({tag, "_rst_hi"}, hi, 32'h0);
        check({tag, "_rst_lo"}, lo, 32'h0);
        check({tag, "_rst_busy"}, 32'(busy), 32'h0);
        check({tag, "_rst_ready"}, 32'(ready), 32'h0);
        reset = 1'b0;
      end
      if (reset_k >= 0 && k == reset_k - 1) reset = 1'b1;
      if (pulse_k >= 0 && k == pulse_k - 1) begin
        a = 32'd9; b = 32'd3; start = 1'b1;
      end
      if (pulse_k >= 0 && k == pulse_k) start = 1'b0;
    end
  endtask

  task automatic div_case(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int ra, rc, bc;
    logic [31:0] ls, hs;
    run(tag, av, bv, -1, -1, ra, rc, bc, ls, hs);
    check({tag, "_lo"}, ls, exp_lo);
    check({tag, "_hi"}, hs, exp_hi);
    check({tag, "_ready_at"}, 32'(ra), 32'd34);
    check({tag, "_ready_cnt"}, 32'(rc), 32'd1);
    check({tag, "_busy_cnt"}, 32'(bc), 32'd34);
  endtask

  initial begin
    int ra, rc, bc, dz_cnt, rdy_seen;
    logic [31:0] ls, hs;

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_ready", 32'(ready), 32'h0);
    check("reset_dz", 32'(div_zero), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    reset = 1'b0;

    div_case("p7_p2", 32'd7, 32'd2, 32'd3, 32'd1);

    // Divide by zero: one-cycle flag, outputs held at 7/2 result.
    @(posedge clk); #1;
    a = 32'd5; b = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("dz_pulse", 32'(div_zero), 32'h1);
    check("dz_busy", 32'(busy), 32'h0);
    check("dz_ready", 32'(ready), 32'h0);
    dz_cnt = 0; rdy_seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (div_zero) dz_cnt++;
      if (ready || busy) rdy_seen++;
    end
    check("dz_width", 32'(dz_cnt), 32'h0);
    check("dz_no_activity", 32'(rdy_seen), 32'h0);
    check("dz_hold_lo", lo, 32'd3);
    check("dz_hold_hi", hi, 32'd1);

    div_case("n7_p2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    div_case("p7_n2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    div_case("n7_n2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
    div_case("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
    div_case("p3_p10", 32'd3, 32'd10, 32'd0, 32'd3);
    div_case("n1_n1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0);

    // Second start while busy is ignored.
    run("busy_ign", 32'd100, 32'd7, 10, -1, ra, rc, bc, ls, hs);
    check("busy_ign_lo", ls, 32'd14);
    check("busy_ign_hi", hs, 32'd2);
    check("busy_ign_ready_at", 32'(ra), 32'd34);
    check("busy_ign_ready_cnt", 32'(rc), 32'd1);

    // Reset mid-operation aborts with no later ready.
    run("abort", 32'd100, 32'd7, -1, 15, ra, rc, bc, ls, hs);
    check("abort_ready_cnt", 32'(rc), 32'd0);
    check("abort_lo_after", lo, 32'd0);

    div_case("p9_p3", 32'd9, 32'd3, 32'd3, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
